div_iter_unit: RTL
==================

Name: div_iter_unit

Overview:
- Multi-cycle iterative integer divider for the EXE stage. Executes MIPS DIV and DIVU.
- Produces the divider-busy signal that the hazard/bypass logic uses to stall a following DIV. It is the producer end of that busy/stall handshake.
- Returns quotient and remainder for the HI/LO write (LO = quotient, HI = remainder).
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- div_start  in  1  DIV/DIVU in EXE is valid this cycle; request a divide.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- dividend  in  WIDTH  rs value; sampled with div_start.
- divisor  in  WIDTH  rt value; sampled with div_start.
- cancel  in  1  pipeline flush (exception/eret); aborts any divide in flight.
- div_busy  out  1  divide in progress; consumed by the hazard unit as DIV_Busy.
- div_done  out  1  one-cycle pulse: quotient/remainder valid and HI/LO must be written.
- quotient  out  WIDTH  result for LO; held until the next accepted start.
- remainder  out  WIDTH  result for HI; held until the next accepted start.

Behaviour:
- Reset (rst low at an edge): state IDLE, counter 0, div_busy=0, div_done=0, quotient=0, remainder=0. Reset mid-divide discards the operation; no done pulse follows.
- States:
  - IDLE -> CALC on an accepted start.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE, pulsing done.
  - A start is accepted only when div_busy=0 (IDLE, or the FIX-output cycle).
  - A start presented while div_busy=1 is ignored. No queueing; the hazard unit's stall prevents it.
- Accept edge E0:
  - Latch the sign flags.
  - Latch |dividend| and |divisor| (absolute value only when div_signed=1).
  - Clear the partial remainder; counter=0.
- CALC, edges E1..E32, one step per edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract rem - divisor in WIDTH+1 bits.
  - If the result is non-negative, commit it and set quo[0]=1.
  - Counter increments each step; leave CALC when counter reaches WIDTH-1.
- FIX, edge E33:
  - Register the outputs.
  - Quotient is negated if the signs differed (signed only).
  - Remainder takes the sign of the dividend (signed only).
  - div_done=1 for exactly the cycle after E33.
- Timing:
  - div_busy=1 in the cycles after E0 through E33, i.e. 33 cycles.
  - div_busy falls in the same cycle div_done rises.
- Divide by zero (no trap in MIPS): quotient = all-ones, remainder = dividend, both before sign fix. Results are the natural restoring results; latency unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, with no overflow flag. The |x| datapath of WIDTH+1 bits handles 2^31 correctly.
- cancel:
  - Any state goes to IDLE at the next edge; div_busy=0 next cycle; no div_done.
  - quotient/remainder keep their previous values.
  - cancel and div_start in the same cycle: cancel wins and the start is dropped.
- Start during the done cycle: accepted. New busy begins the next cycle; outputs hold until the next FIX.
- Outputs are registered; no combinational path from inputs to div_busy/div_done.

Decomposition:
- Shared package div_pkg:
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - WIDTH/CNT_W defaults.
  - DIV_LATENCY=34 (start edge to done visible), for the bench and hazard-unit documentation.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Keeps the FSM file clean and is unit-testable on its own.

Test Plan:
- DIVU 100/7, start pulse at cycle 0 -> div_busy high cycles 1-33; div_done only at cycle 34; quotient=14, remainder=2; busy=0 at cycle 34.
- DIV -7/2 (0xFFFFFFF9 / 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 7/-2 -> quotient=-3, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 5/0 -> quotient=0xFFFFFFFF, remainder=5. No hang; latency 34.
- Start at cycle 0, second start at cycle 10 (busy) -> second ignored; single done at cycle 34 with the first result. Start again in the done cycle -> accepted, next done at cycle 68.
- cancel at cycle 15 of a divide -> busy=0 at cycle 16, no done pulse, previous results held. cancel+start together -> stays IDLE.
- rst low at cycle 20 mid-divide -> next cycle busy=0, done=0, quotient=remainder=0. A fresh start after rst returns high completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: state encoding, default sizes
// and the start-to-done latency seen by the hazard unit.
package div_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int CNT_W_DEF   = 6;
    localparam int DIV_LATENCY = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    // Compare in WIDTH+1 bits; when it passes, the difference is below the
    // divisor, so the low WIDTH bits of the subtraction are exact.
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;

    always_comb begin
        o_rem = w_shift[WIDTH-1:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (w_ge) begin
            o_rem    = w_diff;
            o_quo[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided one bit per cycle, then
// signs are applied in a final FIX cycle that also pulses div_done.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic             w_accept;

    assign w_neg_a  = div_signed & dividend[WIDTH-1];
    assign w_neg_b  = div_signed & divisor[WIDTH-1];
    // Unsigned view of -2^(WIDTH-1) is 2^(WIDTH-1), so no overflow case.
    assign w_abs_a  = w_neg_a ? -dividend : dividend;
    assign w_abs_b  = w_neg_b ? -divisor  : divisor;
    assign w_accept = (r_state == IDLE) && div_start && !cancel;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (div_start) w_next_state = CALC;
            CALC:    if (r_cnt == CNT_W'(WIDTH - 1)) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (cancel) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_rem     <= '0;
                r_quo     <= w_abs_a;
                r_divisor <= w_abs_b;
                r_neg_q   <= w_neg_a ^ w_neg_b;
                r_neg_r   <= w_neg_a;
                r_cnt     <= '0;
            end else if (r_state == CALC && !cancel) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == FIX && !cancel) begin
                r_quotient  <= r_neg_q ? -r_quo : r_quo;
                r_remainder <= r_neg_r ? -r_rem : r_rem;
                r_done      <= 1'b1;
            end
        end
    end

    assign div_busy  = (r_state != IDLE);
    assign div_done  = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
